ssp_tx_fifo: RTL and testbench

- Transmit FIFO that sits directly upstream of the SSP transmit/receive logic.
- Accepts 8-bit words from the APB write side and presents the head word on TxData with tx_ready.
- Holds that word stable for the full serial frame. Pops it only after the transmit logic signals completion on transmit_complete.
- Drives SSPTXINTR when full.

---
 rtl/ssp_tx_fifo.sv | 116 +++++++++++
 tb/tb_ssp_tx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: transmit FIFO feeding the SSP serial engine.
// Ports: PCLK, CLEAR_B (async low), APB write side PSEL/PWRITE/PWDATA,
//        transmit_complete from the serial engine, TxData/tx_ready head
//        word handshake, SSPTXINTR full flag.
// Build option SSP_TX_FIFO_OVF_EN adds a sticky tx_overflow output.
module ssp_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             PCLK,
    input  logic             CLEAR_B,
    input  logic             PSEL,
    input  logic             PWRITE,
    input  logic [WIDTH-1:0] PWDATA,
    input  logic             transmit_complete,
    output logic [WIDTH-1:0] TxData,
    output logic             tx_ready,
`ifdef SSP_TX_FIFO_OVF_EN
    output logic             tx_overflow,
`endif
    output logic             SSPTXINTR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             wr_req;
    logic             wr_en;
    logic             pop;

    assign full   = (count == FULL_CNT);
    assign wr_req = PSEL && PWRITE;
    // Fullness is taken before this edge's pop, so a write racing a pop
    // on a full FIFO is still dropped.
    assign wr_en  = wr_req && !full;

    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                tx_ready = (count != '0) && transmit_complete;
                if (tx_ready)
                    state_nxt = LAUNCH;
            end
            LAUNCH: begin
                if (!transmit_complete)
                    state_nxt = SEND;
            end
            SEND: begin
                if (transmit_complete) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge PCLK) begin
        if (wr_en)
            mem[wr_ptr] <= PWDATA;
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (pop && !wr_en)
                count <= count - 1'b1;
        end
    end

`ifdef SSP_TX_FIFO_OVF_EN
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B)
            tx_overflow <= 1'b0;
        else if (wr_req && full)
            tx_overflow <= 1'b1;
    end
`endif

    assign TxData    = (count != '0) ? mem[rd_ptr] : '0;
    assign SSPTXINTR = full;

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo: scoreboard bench for ssp_tx_fifo with a frame-level
// consumer model and randomized write traffic.
module tb_ssp_tx_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       CLEAR_B;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic       tc;
    logic [7:0] TxData;
    logic       tx_ready;
    logic       SSPTXINTR;
`ifdef SSP_TX_FIFO_OVF_EN
    logic       tx_overflow;
`endif

    always #5 clk = ~clk;

    ssp_tx_fifo #(.WIDTH(8), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .PCLK              (clk),
        .CLEAR_B           (CLEAR_B),
        .PSEL              (PSEL),
        .PWRITE            (PWRITE),
        .PWDATA            (PWDATA),
        .transmit_complete (tc),
        .TxData            (TxData),
        .tx_ready          (tx_ready),
`ifdef SSP_TX_FIFO_OVF_EN
        .tx_overflow       (tx_overflow),
`endif
        .SSPTXINTR         (SSPTXINTR)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] launched[$];
    logic [7:0] exp_seq[$];
    logic       ovf_m = 1'b0;

    logic hold = 1'b0;
    int   flen = 8;
    logic busy = 1'b0;
    logic pop_next = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Consumer: samples tx_ready, holds transmit_complete low for flen
    // edges, then raises it; the FIFO pops on the next edge.
    initial begin
        logic rdy_s;
        int   left;
        tc   = 1'b1;
        left = 0;
        forever begin
            @(negedge clk);
            rdy_s = tx_ready && CLEAR_B;
            @(posedge clk);
            #1;
            if (!busy) begin
                if (rdy_s) begin
                    busy = 1'b1;
                    tc   = 1'b0;
                    left = flen;
                end else begin
                    tc = !hold;
                end
            end else if (pop_next) begin
                busy     = 1'b0;
                pop_next = 1'b0;
                tc       = !hold;
            end else if (left > 1) begin
                left--;
            end else begin
                tc       = 1'b1;
                pop_next = 1'b1;
            end
        end
    end

    // Reference model: FIFO contents as a queue; checks the outputs that
    // hold before the coming edge, then applies that edge's write/pop.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!CLEAR_B) begin
            q.delete();
            exp_q.delete();
            ovf_m = 1'b0;
        end
        exp_rdy = !busy && (q.size() > 0) && tc && CLEAR_B;
        chk("tx_ready", tx_ready, exp_rdy);
        chk("full", SSPTXINTR, q.size() == DEPTH);
        chk("txdata", TxData, (q.size() > 0) ? q[0] : 8'h00);
`ifdef SSP_TX_FIFO_OVF_EN
        chk("overflow", tx_overflow, ovf_m);
`endif
        if (CLEAR_B) begin
            if (PSEL && PWRITE) begin
                if (q.size() < DEPTH) begin
                    q.push_back(PWDATA);
                    exp_q.push_back(PWDATA);
                end else begin
                    ovf_m = 1'b1;
                end
            end
            if (pop_next && q.size() > 0)
                void'(q.pop_front());
        end
    end

    // Scoreboard monitor: each launch must present the oldest
    // accepted word not yet launched.
    always @(negedge clk) begin
        logic [7:0] w;
        if (tx_ready) begin
            launched.push_back(TxData);
            if (exp_q.size() == 0) begin
                chk("launch_unexpected", {24'h0, TxData}, 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("launch_word", TxData, w);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] d);
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = d;
        cyc();
        PSEL   = 1'b0;
        PWRITE = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 400) begin
            cyc();
            n++;
        end
        chk("drain_done", (q.size() == 0) && !busy, 1);
    endtask

    task automatic wait_pop();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!pop_next && n < 100);
        chk("pop_seen", pop_next, 1);
    endtask

    task automatic chk_seq(input string nm, input int base);
        chk({nm, "_len"}, launched.size() - base, exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++)
            if (base + i < launched.size())
                chk(nm, launched[base + i], exp_seq[i]);
    endtask

    initial begin
        int base;
        CLEAR_B = 1'b0;
        PSEL    = 1'b0;
        PWRITE  = 1'b0;
        PWDATA  = 8'h00;
        #1;
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_full", SSPTXINTR, 0);
        chk("rst_txdata", TxData, 0);
        repeat (3) cyc();
        CLEAR_B = 1'b1;
        cyc();

        // Single word, 8-cycle frame
        wr(8'hA5);
        @(negedge clk);
        chk("a5_ready", tx_ready, 1);
        chk("a5_data", TxData, 8'hA5);
        chk("a5_full", SSPTXINTR, 0);
        drain();
        @(negedge clk);
        chk("a5_empty_ready", tx_ready, 0);
        chk("a5_empty_data", TxData, 0);

        // Fill, overflow, drain order
        hold = 1'b1;
        cyc();
        cyc();
        base = launched.size();
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        @(negedge clk);
        chk("fill_full", SSPTXINTR, 1);
        wr(8'h55);
        @(negedge clk);
        chk("drop_full", SSPTXINTR, 1);
`ifdef SSP_TX_FIFO_OVF_EN
        chk("drop_ovf", tx_overflow, 1);
`endif
        hold = 1'b0;
        flen = 2;
        drain();
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk_seq("drain_order", base);

        // Full FIFO: write on the pop edge is dropped
        hold = 1'b1;
        cyc();
        cyc();
        base = launched.size();
        wr(8'h61); wr(8'h62); wr(8'h63); wr(8'h64);
        hold = 1'b0;
        flen = 3;
        wait_pop();
        wr(8'h66);
        @(negedge clk);
        chk("fullpop_full", SSPTXINTR, 0);
        drain();
        exp_seq = '{8'h61, 8'h62, 8'h63, 8'h64};
        chk_seq("fullpop_order", base);

        // count=2: write on the pop edge is kept behind the survivor
        hold = 1'b1;
        cyc();
        cyc();
        base = launched.size();
        wr(8'h21); wr(8'h22);
        hold = 1'b0;
        wait_pop();
        wr(8'h23);
        @(negedge clk);
        chk("twopop_full", SSPTXINTR, 0);
        drain();
        exp_seq = '{8'h21, 8'h22, 8'h23};
        chk_seq("twopop_order", base);

        // Pointer wrap
        base = launched.size();
        exp_seq.delete();
        for (int i = 1; i <= 10; i++) begin
            wr(8'(i));
            exp_seq.push_back(8'(i));
            @(negedge clk);
            chk("wrap_full", SSPTXINTR, 0);
            drain();
        end
        chk_seq("wrap_order", base);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            PSEL   = ($urandom_range(0, 2) != 0);
            PWRITE = ($urandom_range(0, 3) != 0);
            PWDATA = 8'($urandom);
            if ($urandom_range(0, 15) == 0)
                hold = ~hold;
            flen = $urandom_range(1, 6);
            cyc();
        end
        PSEL   = 1'b0;
        PWRITE = 1'b0;
        hold   = 1'b0;
        drain();

        // Reset during SEND with three words queued
        hold = 1'b1;
        cyc();
        cyc();
        wr(8'h31); wr(8'h32); wr(8'h33);
        flen = 8;
        hold = 1'b0;
        begin
            int n;
            n = 0;
            while (!busy && n < 50) begin
                cyc();
                n++;
            end
            chk("rst_busy", busy, 1);
        end
        repeat (3) cyc();
        CLEAR_B = 1'b0;
        #1;
        chk("midrst_ready", tx_ready, 0);
        chk("midrst_full", SSPTXINTR, 0);
        chk("midrst_data", TxData, 0);
        begin
            int n;
            n = 0;
            while (busy && n < 50) begin
                cyc();
                n++;
            end
            chk("rst_frame_end", busy, 0);
        end
        cyc();
        CLEAR_B = 1'b1;
        cyc();
        base = launched.size();
        wr(8'h7E);
        drain();
        exp_seq = '{8'h7E};
        chk_seq("after_rst", base);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
